digit_scan_reader: RTL and testbench
====================================

# digit_scan_reader

- Reads four 4-bit digit registers, packed as one 16-bit bus, and time-multiplexes them onto a common-anode 4-digit seven-segment display.
- Decodes each nibble to hex segments and suppresses leading zeros on request.
- Snapshots the register contents once per scan frame, so a mid-frame update to the registers never produces a torn display.
- Sits between the digit registers (the writers) and the display pins, acting as their reader.

## Interface
- DIV, 100000, clock cycles per digit slot; legal range ≥ 4.
- GUARD, 2, cycles at the start of each slot with all anodes off (anti-ghosting); legal range 1 ≤ GUARD < DIV.
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- data  input  16  four register outputs: digit0 = data[3:0] (rightmost) … digit3 = data[15:12].
- dp_sel  input  4  per-digit decimal point request, active-high; bit i belongs to digit i.
- lz_en  input  1  leading-zero blanking enable.
- an  output  4  anode enables, active-low; an[i] drives digit i.
- seg  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.
- frame  output  1  one-cycle pulse marking each new snapshot.

## Operation
- State:
  - prescaler `cnt` (0..DIV-1)
  - digit index `idx` (0..3)
  - snapshot registers `snap[15:0]`, `snap_dp[3:0]`, `snap_lz`
  - `primed` flag
- Prescaler:
  - `cnt` increments every cycle and wraps DIV-1 → 0.
  - `tick` = (cnt == DIV-1).
- Digit index: on `tick`, `idx` advances 0→1→2→3→0.
- Snapshot loads `data`, `dp_sel` and `lz_en` into the snapshot registers and sets `frame` = 1 on the same edge. It occurs on exactly two kinds of edge:
  - the first edge after reset deasserts (`primed` = 0; `primed` is then set to 1);
  - every edge where `tick` && `idx` == 3, i.e. the wrap to digit 0.
- At every other edge `frame` = 0. Inputs are ignored between snapshots.
- Leading-zero blanking is active only when `snap_lz` = 1:
  - digit3 is blanked if snap[15:12] == 0;
  - digit2 is blanked if snap[15:8] == 0;
  - digit1 is blanked if snap[15:4] == 0;
  - digit0 is never blanked.
  - A blanked digit keeps its anode high for its whole slot.
- Hex decode, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Output selection, computed from the current state:
  - During guard (cnt < GUARD), or when the digit is blanked: an = 1111, seg = 1111111, dp = 1.
  - Otherwise: an = ~(1 << idx), seg = decode(snap nibble idx), dp = ~snap_dp[idx].

## Timing
- `an`, `seg`, `dp` and `frame` are registered. Each is the function of the state present before the edge, so outputs lag the state by one cycle.
- Reset values (asynchronous, immediate on reset assertion):
  - an = 1111, seg = 1111111, dp = 1, frame = 0
  - cnt = 0, idx = 0, snap = 0, snap_dp = 0, snap_lz = 0, primed = 0
- Reset mid-slot or mid-frame: the display blanks immediately. After release, the scan restarts at digit 0 with a fresh snapshot on the first edge.
- Each digit slot is DIV cycles, of which DIV-GUARD are lit. A frame is 4·DIV cycles.
- `frame` pulses once per 4·DIV cycles, plus one extra pulse after reset release.
- No snapshot occurs other than the two cases above. A `data` change in the same cycle as the wrap tick is captured.

## Test plan
Parameters: DIV = 8, GUARD = 2, dp_sel = 0, lz_en = 0 unless stated.
1. Reset: assert reset asynchronously mid-slot → an = 1111, seg = 1111111, dp = 1 and frame = 0 before the next clk edge. Release → frame = 1 for exactly one cycle.
2. Scan order: data = 16'h1234 → anodes cycle 1110, 1101, 1011, 0111, each lit 6 cycles with 2 blank guard cycles before it. seg = 0011001, 0110000, 0100100, 1111001 respectively. frame pulses every 32 cycles.
3. Tear-free update: switch data to 16'hABCD while idx = 1 → digits 1–3 still show 3, 2, 1 for the rest of the frame. At the wrap, frame = 1 and digit0 shows d (0100001), then C, b, A.
4. Leading-zero blanking:
   - data = 16'h0070, lz_en = 1 → an[3] and an[2] stay 1 for the whole frame; digit1 = 1111000, digit0 = 1000000.
   - data = 16'h0000 → only an[0] ever goes low.
   - lz_en = 0 → all four digits show 0.
5. Decimal point: data = 16'h8888, dp_sel = 4'b0100 → dp = 0 only while an = 1011, seg = 0000000 throughout the lit time.
6. Reset mid-frame: assert reset during idx = 2, set data = 16'hF00F, release → the next lit digit is digit0 = 0001110 with no digit2 slot first.

Source files
------------

// File: rtl/digit_scan_reader.sv
// Time-multiplexed reader for four hex digit registers driving a common-anode
// 4-digit seven-segment display, with per-frame snapshots and leading-zero blanking.
module digit_scan_reader #(
   parameter int unsigned DIV   = 100000,
   parameter int unsigned GUARD = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] data,
   input  logic [3:0]  dp_sel,
   input  logic        lz_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame
);

   localparam int unsigned    CW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0]  GUARD_CNT = CW'(GUARD);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   snap_q, snap_d;
   logic [3:0]    snap_dp_q, snap_dp_d;
   logic          snap_lz_q, snap_lz_d;
   logic          primed_q, primed_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          frame_q, frame_d;

   logic          tick;
   logic          load;
   logic          blank;
   logic [3:0]    nib;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_comb begin
      tick = (cnt_q == CNT_LAST);
      // Snapshot on the first edge after reset and on every wrap back to digit 0.
      load = !primed_q || (tick && (idx_q == 2'd3));

      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      idx_d     = tick ? idx_q + 2'd1 : idx_q;
      snap_d    = load ? data   : snap_q;
      snap_dp_d = load ? dp_sel : snap_dp_q;
      snap_lz_d = load ? lz_en  : snap_lz_q;
      primed_d  = 1'b1;
      frame_d   = load;

      nib = snap_q[{idx_q, 2'b00} +: 4];
      case (idx_q)
         2'd3:    blank = snap_lz_q && (snap_q[15:12] == 4'h0);
         2'd2:    blank = snap_lz_q && (snap_q[15:8]  == 8'h00);
         2'd1:    blank = snap_lz_q && (snap_q[15:4]  == 12'h000);
         default: blank = 1'b0;
      endcase

      if ((cnt_q < GUARD_CNT) || blank) begin
         an_d  = '1;
         seg_d = '1;
         dp_d  = 1'b1;
      end else begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = hex7(nib);
         dp_d  = ~snap_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         snap_q    <= '0;
         snap_dp_q <= '0;
         snap_lz_q <= 1'b0;
         primed_q  <= 1'b0;
         an_q      <= '1;
         seg_q     <= '1;
         dp_q      <= 1'b1;
         frame_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         snap_q    <= snap_d;
         snap_dp_q <= snap_dp_d;
         snap_lz_q <= snap_lz_d;
         primed_q  <= primed_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         frame_q   <= frame_d;
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = dp_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_digit_scan_reader.sv
// Directed bench for digit_scan_reader with DIV=8, GUARD=2; outputs sampled 1ns after each rising edge.
module tb_digit_scan_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data;
   logic [3:0]  dp_sel;
   logic        lz_en;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame;

   int unsigned tests = 0;
   int unsigned fails = 0;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S7 = 7'b1111000, S8 = 7'b0000000;
   localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110, SD = 7'b0100001;
   localparam logic [6:0] SF = 7'b0001110;
   localparam logic [12:0] BLANK0 = {4'b1111, 7'b1111111, 1'b1, 1'b0};

   digit_scan_reader #(.DIV(8), .GUARD(2)) dut (
      .clk    (clk),
      .reset  (reset),
      .data   (data),
      .dp_sel (dp_sel),
      .lz_en  (lz_en),
      .an     (an),
      .seg    (seg),
      .dp     (dp),
      .frame  (frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: {an,seg,dp,frame} got %b want %b", tag, obs, exp_v);
      end
   endtask

   // One 8-cycle slot of digit d: 2 guard cycles then 6 lit (unless blanked).
   task automatic scan_slot(input string tag, input int d, input logic [6:0] sg, input bit lit,
                            input bit dpon, input bit f_first, input bit f_last);
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      logic       ef;
      for (int j = 0; j < 8; j++) begin
         @(posedge clk); #1;
         if (j < 2 || !lit) begin
            ea = 4'b1111; es = 7'b1111111; ed = 1'b1;
         end else begin
            ea = ~(4'b0001 << d); es = sg; ed = ~dpon;
         end
         ef = (j == 0) ? f_first : ((j == 7) ? f_last : 1'b0);
         chk($sformatf("%s d%0d c%0d", tag, d, j), {an, seg, dp, frame}, {ea, es, ed, ef});
      end
   endtask

   initial begin
      reset = 1'b1; data = 16'h1234; dp_sel = 4'h0; lz_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hold", {an, seg, dp, frame}, BLANK0);

      // Scan order with 1234, including the extra post-release frame pulse.
      reset = 1'b0;
      scan_slot("f1", 0, S4, 1, 0, 1, 0);
      scan_slot("f1", 1, S3, 1, 0, 0, 0);
      scan_slot("f1", 2, S2, 1, 0, 0, 0);
      scan_slot("f1", 3, S1, 1, 0, 0, 1);
      scan_slot("f2", 0, S4, 1, 0, 0, 0);
      scan_slot("f2", 1, S3, 1, 0, 0, 0);
      scan_slot("f2", 2, S2, 1, 0, 0, 0);
      scan_slot("f2", 3, S1, 1, 0, 0, 1);

      // Tear-free: change during digit1 is held off until the wrap.
      scan_slot("f3", 0, S4, 1, 0, 0, 0);
      data = 16'hABCD;
      scan_slot("f3", 1, S3, 1, 0, 0, 0);
      scan_slot("f3", 2, S2, 1, 0, 0, 0);
      scan_slot("f3", 3, S1, 1, 0, 0, 1);
      scan_slot("f4", 0, SD, 1, 0, 0, 0);
      scan_slot("f4", 1, SC, 1, 0, 0, 0);
      scan_slot("f4", 2, SB, 1, 0, 0, 0);
      data = 16'h0070; lz_en = 1'b1;
      scan_slot("f4", 3, SA, 1, 0, 0, 1);

      // Leading-zero blanking.
      scan_slot("lz70", 0, S0, 1, 0, 0, 0);
      scan_slot("lz70", 1, S7, 1, 0, 0, 0);
      scan_slot("lz70", 2, S0, 0, 0, 0, 0);
      data = 16'h0000;
      scan_slot("lz70", 3, S0, 0, 0, 0, 1);
      scan_slot("lz00", 0, S0, 1, 0, 0, 0);
      scan_slot("lz00", 1, S0, 0, 0, 0, 0);
      scan_slot("lz00", 2, S0, 0, 0, 0, 0);
      lz_en = 1'b0;
      scan_slot("lz00", 3, S0, 0, 0, 0, 1);
      scan_slot("nolz", 0, S0, 1, 0, 0, 0);
      scan_slot("nolz", 1, S0, 1, 0, 0, 0);
      scan_slot("nolz", 2, S0, 1, 0, 0, 0);
      data = 16'h8888; dp_sel = 4'b0100;
      scan_slot("nolz", 3, S0, 1, 0, 0, 1);

      // Decimal point on digit2 only.
      scan_slot("dp", 0, S8, 1, 0, 0, 0);
      scan_slot("dp", 1, S8, 1, 0, 0, 0);
      scan_slot("dp", 2, S8, 1, 1, 0, 0);
      scan_slot("dp", 3, S8, 1, 0, 0, 1);

      // Reset asserted mid-slot during digit2 blanks outputs before the next edge.
      scan_slot("pre", 0, S8, 1, 0, 0, 0);
      scan_slot("pre", 1, S8, 1, 0, 0, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("lit_before_rst", {an, seg, dp, frame}, {4'b1011, S8, 1'b0, 1'b0});
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst", {an, seg, dp, frame}, BLANK0);
      data = 16'hF00F; dp_sel = 4'h0;
      @(posedge clk); #1;
      chk("rst_held", {an, seg, dp, frame}, BLANK0);
      reset = 1'b0;
      scan_slot("post", 0, SF, 1, 0, 1, 0);
      scan_slot("post", 1, S0, 1, 0, 0, 0);
      scan_slot("post", 2, S0, 1, 0, 0, 0);
      scan_slot("post", 3, SF, 1, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
